// File: rtl/ether_pkg.sv
// rtl/ether_pkg.sv - shared constants for the multi-message RMII receive path
package ether_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_PREAMBLE  = 3'd1;
    localparam state_t ST_DST_MAC   = 3'd2;
    localparam state_t ST_SRC_MAC   = 3'd3;
    localparam state_t ST_ETHERTYPE = 3'd4;
    localparam state_t ST_PAYLOAD   = 3'd5;
    localparam state_t ST_DROP      = 3'd6;

    localparam logic [7:0]  OP_READ       = 8'd0;
    localparam logic [7:0]  OP_WRITE      = 8'd1;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    // 0x55 preamble bytes are all 01 dibits; the SFD 0xD5 ends on an 11 dibit.
    localparam logic [1:0] DIBIT_PREAMBLE = 2'b01;
    localparam logic [1:0] DIBIT_SFD      = 2'b11;

    function automatic logic is_valid_opcode(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/rmii_byte_asm.sv
// rtl/rmii_byte_asm.sv - RMII dibit-to-byte shifter, LSB dibit first
module rmii_byte_asm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid
);

    logic [5:0] shift_q;
    logic [1:0] cnt_q;

    // The byte is presented combinationally while its 4th dibit is on the wire.
    assign byte_valid = en && !clr && (cnt_q == 2'd3);
    assign byte_data  = {rxd, shift_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            shift_q <= {rxd, shift_q[5:2]};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/ethernet_rx_multi.sv
// rtl/ethernet_rx_multi.sv - RMII frame filter and multi-message register request parser
module ethernet_rx_multi
    import ether_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC  = 48'h0,
    parameter logic [15:0] ETHERTYPE = 16'h0,
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 16,
    parameter int          MAX_MSGS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              crsdv,
    input  logic [1:0]        rxd,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              rw_o,
    output logic              valid_o,
    output logic              drop_o,
    output logic [15:0]       drop_count_o
);

    localparam int MB    = 1 + ADDR_W / 8 + DATA_W / 8;
    localparam int MSG_W = MB * 8;
    localparam int IDX_W = $clog2(MAX_MSGS + 1);

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [39:0]        hdr_q;
    logic [MSG_W-9:0]   msg_q;

    logic [7:0]         byte_data;
    logic               byte_valid;
    logic               asm_clr;
    logic [47:0]        hdr_next;
    logic [MSG_W-1:0]   msg_full;
    logic [7:0]         opcode;
    logic [ADDR_W-1:0]  msg_addr;
    logic [DATA_W-1:0]  msg_data;

    assign asm_clr  = !crsdv || (state_q == ST_PREAMBLE && rxd == DIBIT_SFD);
    assign hdr_next = {hdr_q, byte_data};
    assign msg_full = {msg_q, byte_data};
    assign opcode   = msg_full[MSG_W-1 -: 8];
    assign msg_addr = msg_full[DATA_W +: ADDR_W];
    assign msg_data = msg_full[DATA_W-1:0];

    rmii_byte_asm u_byte_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (crsdv),
        .clr        (asm_clr),
        .rxd        (rxd),
        .byte_data  (byte_data),
        .byte_valid (byte_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            hdr_q        <= '0;
            msg_q        <= '0;
            addr_o       <= '0;
            wdata_o      <= '0;
            rw_o         <= 1'b0;
            valid_o      <= 1'b0;
            drop_o       <= 1'b0;
            drop_count_o <= '0;
        end else begin
            valid_o <= 1'b0;
            drop_o  <= 1'b0;
            if (drop_o && drop_count_o != 16'hFFFF)
                drop_count_o <= drop_count_o + 16'd1;

            case (state_q)
                ST_IDLE: begin
                    if (crsdv && rxd == DIBIT_PREAMBLE)
                        state_q <= ST_PREAMBLE;
                end
                ST_PREAMBLE: begin
                    if (!crsdv) begin
                        state_q <= ST_IDLE;
                    end else if (rxd == DIBIT_SFD) begin
                        state_q <= ST_DST_MAC;
                        cnt_q   <= '0;
                    end else if (rxd != DIBIT_PREAMBLE) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    if (!crsdv) begin
                        // Carrier loss mid-message discards it, but only if it had started.
                        state_q <= ST_IDLE;
                        if (state_q == ST_PAYLOAD && cnt_q != 4'd0)
                            drop_o <= 1'b1;
                    end else if (byte_valid) begin
                        case (state_q)
                            ST_DST_MAC: begin
                                hdr_q <= hdr_next[39:0];
                                if (cnt_q == 4'd5) begin
                                    cnt_q <= '0;
                                    if (hdr_next == FPGA_MAC || hdr_next == BROADCAST_MAC) begin
                                        state_q <= ST_SRC_MAC;
                                    end else begin
                                        state_q <= ST_DROP;
                                        drop_o  <= 1'b1;
                                    end
                                end else begin
                                    cnt_q <= cnt_q + 4'd1;
                                end
                            end
                            ST_SRC_MAC: begin
                                if (cnt_q == 4'd5) begin
                                    cnt_q   <= '0;
                                    state_q <= ST_ETHERTYPE;
                                end else begin
                                    cnt_q <= cnt_q + 4'd1;
                                end
                            end
                            ST_ETHERTYPE: begin
                                hdr_q <= hdr_next[39:0];
                                if (cnt_q == 4'd1) begin
                                    cnt_q <= '0;
                                    if (hdr_next[15:0] == ETHERTYPE) begin
                                        state_q <= ST_PAYLOAD;
                                        idx_q   <= '0;
                                    end else begin
                                        state_q <= ST_DROP;
                                        drop_o  <= 1'b1;
                                    end
                                end else begin
                                    cnt_q <= cnt_q + 4'd1;
                                end
                            end
                            ST_PAYLOAD: begin
                                msg_q <= msg_full[MSG_W-9:0];
                                if (cnt_q == 4'(MB - 1)) begin
                                    cnt_q <= '0;
                                    if (is_valid_opcode(opcode)) begin
                                        valid_o <= 1'b1;
                                        addr_o  <= msg_addr;
                                        wdata_o <= (opcode == OP_WRITE) ? msg_data : '0;
                                        rw_o    <= opcode[0];
                                    end else begin
                                        drop_o <= 1'b1;
                                    end
                                    // Bytes beyond the last permitted message are ignored silently.
                                    if (idx_q == IDX_W'(MAX_MSGS - 1))
                                        state_q <= ST_DROP;
                                    idx_q <= idx_q + IDX_W'(1);
                                end else begin
                                    cnt_q <= cnt_q + 4'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_rx_multi.sv
// tb/tb_ethernet_rx_multi.sv - self-checking bench for ethernet_rx_multi
module tb_ethernet_rx_multi;

    localparam logic [47:0] MAC   = 48'h1234_5678_9ABC;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETYPE = 16'h1234;
    localparam int          MAXM  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        crsdv, crsdv_w;
    logic [1:0]  rxd, rxd_w;
    logic [15:0] addr_o, wdata_o, drop_count_o;
    logic        rw_o, valid_o, drop_o;
    logic [31:0] addr_w;
    logic [7:0]  wdata_w;
    logic        rw_w, valid_w, drop_w;
    logic [15:0] dcount_w;

    ethernet_rx_multi #(.FPGA_MAC(MAC), .ETHERTYPE(ETYPE), .ADDR_W(16), .DATA_W(16), .MAX_MSGS(MAXM)) dut (
        .clk(clk), .rst_n(rst_n), .crsdv(crsdv), .rxd(rxd), .addr_o(addr_o), .wdata_o(wdata_o),
        .rw_o(rw_o), .valid_o(valid_o), .drop_o(drop_o), .drop_count_o(drop_count_o));

    ethernet_rx_multi #(.FPGA_MAC(MAC), .ETHERTYPE(ETYPE), .ADDR_W(32), .DATA_W(8), .MAX_MSGS(MAXM)) dut_w (
        .clk(clk), .rst_n(rst_n), .crsdv(crsdv_w), .rxd(rxd_w), .addr_o(addr_w), .wdata_o(wdata_w),
        .rw_o(rw_w), .valid_o(valid_w), .drop_o(drop_w), .drop_count_o(dcount_w));

    always #10 clk = ~clk;

    typedef struct packed {
        int          t;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
    } ev_t;

    typedef struct packed {
        logic [47:0]  dst;
        logic [15:0]  et;
        logic [239:0] pay;
        int           npay;
        int           nv;
        int           nd;
        logic [31:0]  fa;
        logic [31:0]  fd;
        logic         frw;
    } vec_t;

    int   cyc = 0;
    ev_t  obs0[$], obs1[$];
    int   ndrop0 = 0, ndrop1 = 0, both_hi = 0;
    int   end_cyc[$];
    int   checks = 0, errors = 0;
    int   etot0 = 0, etot1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) obs0.push_back('{cyc, 32'(addr_o), 32'(wdata_o), rw_o});
        if (valid_w) obs1.push_back('{cyc, addr_w, 32'(wdata_w), rw_w});
        if (drop_o) ndrop0 <= ndrop0 + 1;
        if (drop_w) ndrop1 <= ndrop1 + 1;
        if ((valid_o && drop_o) || (valid_w && drop_w)) both_hi <= both_hi + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic w, input logic cv, input logic [1:0] d);
        @(negedge clk);
        if (w) begin crsdv_w = cv; rxd_w = d; end
        else   begin crsdv   = cv; rxd   = d; end
    endtask

    task automatic send_byte(input logic w, input logic [7:0] b);
        for (int i = 0; i < 4; i++) put(w, 1'b1, b[2*i +: 2]);
        end_cyc.push_back(cyc);
    endtask

    task automatic send_preamble(input logic w);
        end_cyc.delete();
        for (int i = 0; i < 31; i++) put(w, 1'b1, 2'b01);
        put(w, 1'b1, 2'b11);
    endtask

    task automatic end_frame(input logic w);
        for (int i = 0; i < 8; i++) put(w, 1'b0, 2'b00);
    endtask

    task automatic send_frame(input logic w, input logic [7:0] fr[$]);
        send_preamble(w);
        foreach (fr[i]) send_byte(w, fr[i]);
        end_frame(w);
    endtask

    task automatic build_hdr(input logic [47:0] dst, input logic [15:0] et, output logic [7:0] fr[$]);
        logic [47:0] src;
        src = 48'h0200_0000_0001;
        fr = {};
        for (int i = 5; i >= 0; i--) fr.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(src[8*i +: 8]);
        fr.push_back(et[15:8]);
        fr.push_back(et[7:0]);
    endtask

    // Reference: slice the byte stream into fixed-size messages and judge each one.
    task automatic model(input logic w, input logic [7:0] fr[$], output ev_t ex[$], output int ed);
        int mb = w ? 6 : 5;
        int aw = w ? 4 : 2;
        int dw = w ? 1 : 2;
        int nfull, rem;
        logic [47:0] dst;
        ex = {};
        ed = 0;
        if (fr.size() < 6) return;
        dst = '0;
        for (int i = 0; i < 6; i++) dst = {dst[39:0], fr[i]};
        if (dst != MAC && dst != BCAST) begin ed = 1; return; end
        if (fr.size() < 14) return;
        if ({fr[12], fr[13]} != ETYPE) begin ed = 1; return; end
        nfull = (fr.size() - 14) / mb;
        rem   = (fr.size() - 14) % mb;
        for (int k = 0; k < nfull && k < MAXM; k++) begin
            int b = 14 + k * mb;
            logic [31:0] a = '0;
            logic [31:0] d = '0;
            for (int i = 0; i < aw; i++) a = (a << 8) | 32'(fr[b + 1 + i]);
            for (int i = 0; i < dw; i++) d = (d << 8) | 32'(fr[b + 1 + aw + i]);
            if (fr[b] == 8'd0 || fr[b] == 8'd1)
                ex.push_back('{end_cyc[b + mb - 1] + 1, a, (fr[b] == 8'd1) ? d : 32'd0, fr[b][0]});
            else
                ed++;
        end
        if (nfull < MAXM && rem > 0) ed++;
    endtask

    function automatic ev_t get_ev(input logic w, input int i);
        return w ? obs1[i] : obs0[i];
    endfunction

    task automatic check_frame(input logic w, input logic [7:0] fr[$], input int o_start,
                               input int d_start, input string nm);
        ev_t ex[$];
        ev_t g;
        int  ed, got;
        model(w, fr, ex, ed);
        got = (w ? obs1.size() : obs0.size()) - o_start;
        chk({nm, " model nvalid"}, got, ex.size());
        for (int k = 0; k < got && k < ex.size(); k++) begin
            g = get_ev(w, o_start + k);
            chk($sformatf("%s ev%0d time", nm, k), g.t, ex[k].t);
            chk($sformatf("%s ev%0d addr", nm, k), g.addr, ex[k].addr);
            chk($sformatf("%s ev%0d data", nm, k), g.data, ex[k].data);
            chk($sformatf("%s ev%0d rw", nm, k), g.rw, ex[k].rw);
        end
        chk({nm, " model ndrop"}, (w ? ndrop1 : ndrop0) - d_start, ed);
        if (w) begin
            etot1 += ed;
            chk({nm, " drop_count"}, dcount_w, etot1);
        end else begin
            etot0 += ed;
            chk({nm, " drop_count"}, drop_count_o, etot0);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] dst, input logic [15:0] et, input logic [239:0] pay,
                                input int npay, input int nv, input int nd,
                                input logic [31:0] fa, input logic [31:0] fd, input logic frw);
        return '{dst, et, pay, npay, nv, nd, fa, fd, frw};
    endfunction

    vec_t        tbl[10];
    logic [7:0]  fr[$];
    int          o0, d0;
    logic        w;

    initial begin
        tbl[0] = mk(MAC, ETYPE, 240'h01_0042_BEEF, 5, 1, 0, 32'h42, 32'hBEEF, 1'b1);
        tbl[1] = mk(MAC, ETYPE, 240'h00_0001_1111_01_0002_00AA_00_0003_2222, 15, 3, 0, 32'h1, 32'h0, 1'b0);
        tbl[2] = mk(48'h0000_0000_0001, ETYPE, 240'h01_0042_BEEF, 5, 0, 1, 32'h0, 32'h0, 1'b0);
        tbl[3] = mk(BCAST, ETYPE, 240'h01_0010_0055, 5, 1, 0, 32'h10, 32'h55, 1'b1);
        tbl[4] = mk(MAC, ETYPE, 240'h01_0005_1234_07_0006_5678_01_0007_9ABC, 15, 2, 1, 32'h5, 32'h1234, 1'b1);
        tbl[5] = mk(MAC, ETYPE,
                    240'h01_0001_0011_01_0002_0022_01_0003_0033_01_0004_0044_01_0005_0055_01_0006_0066,
                    30, 4, 0, 32'h1, 32'h11, 1'b1);
        tbl[6] = mk(MAC, ETYPE, 240'h01_0042, 3, 0, 1, 32'h0, 32'h0, 1'b0);
        tbl[7] = mk(MAC, 16'h0800, 240'h01_0042_BEEF, 5, 0, 1, 32'h0, 32'h0, 1'b0);
        tbl[8] = mk(MAC, ETYPE, 240'h01_0042_BEEF_FFFF_FF, 8, 1, 1, 32'h42, 32'hBEEF, 1'b1);
        tbl[9] = mk(MAC, ETYPE, 240'h0, 0, 0, 0, 32'h0, 32'h0, 1'b0);

        rst_n = 1'b0; crsdv = 1'b0; rxd = 2'b00; crsdv_w = 1'b0; rxd_w = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset valid_o", valid_o, 1'b0);
        chk("reset drop_o", drop_o, 1'b0);
        chk("reset addr_o", addr_o, 16'h0);
        chk("reset wdata_o", wdata_o, 16'h0);
        chk("reset drop_count_o", drop_count_o, 16'h0);
        chk("reset wide outputs", {valid_w, drop_w, rw_w, addr_w, wdata_w, dcount_w}, 64'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            build_hdr(tbl[v].dst, tbl[v].et, fr);
            for (int j = 0; j < tbl[v].npay; j++) fr.push_back(tbl[v].pay[(tbl[v].npay - 1 - j) * 8 +: 8]);
            o0 = obs0.size(); d0 = ndrop0;
            send_frame(1'b0, fr);
            chk($sformatf("vec%0d nvalid", v), obs0.size() - o0, tbl[v].nv);
            chk($sformatf("vec%0d ndrop", v), ndrop0 - d0, tbl[v].nd);
            if (tbl[v].nv > 0 && obs0.size() > o0) begin
                chk($sformatf("vec%0d first addr", v), obs0[o0].addr, tbl[v].fa);
                chk($sformatf("vec%0d first data", v), obs0[o0].data, tbl[v].fd);
                chk($sformatf("vec%0d first rw", v), obs0[o0].rw, tbl[v].frw);
            end
            check_frame(1'b0, fr, o0, d0, $sformatf("vec%0d", v));
        end

        // Reset in the middle of a payload, then trailing bytes that must not resynchronise.
        build_hdr(MAC, ETYPE, fr);
        send_preamble(1'b0);
        foreach (fr[i]) send_byte(1'b0, fr[i]);
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset addr_o", addr_o, 16'h0);
        chk("midreset wdata_o", wdata_o, 16'h0);
        chk("midreset drop_count_o", drop_count_o, 16'h0);
        chk("midreset valid/drop", {valid_o, drop_o, rw_o}, 3'b000);
        etot0 = 0; etot1 = 0;
        o0 = obs0.size(); d0 = ndrop0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_byte(1'b0, 8'h42);
        send_byte(1'b0, 8'hBE);
        send_byte(1'b0, 8'hEF);
        end_frame(1'b0);
        chk("postreset nvalid", obs0.size() - o0, 0);
        chk("postreset ndrop", ndrop0 - d0, 0);
        build_hdr(MAC, ETYPE, fr);
        fr.push_back(8'h01); fr.push_back(8'h00); fr.push_back(8'h42); fr.push_back(8'hBE); fr.push_back(8'hEF);
        o0 = obs0.size(); d0 = ndrop0;
        send_frame(1'b0, fr);
        check_frame(1'b0, fr, o0, d0, "clean after reset");

        // Wide instance: 32-bit address, 8-bit data.
        build_hdr(MAC, ETYPE, fr);
        fr.push_back(8'h01); fr.push_back(8'hDE); fr.push_back(8'hAD);
        fr.push_back(8'hBE); fr.push_back(8'hEF); fr.push_back(8'h5A);
        o0 = obs1.size(); d0 = ndrop1;
        send_frame(1'b1, fr);
        chk("wide nvalid", obs1.size() - o0, 1);
        if (obs1.size() > o0) begin
            chk("wide addr", obs1[o0].addr, 32'hDEAD_BEEF);
            chk("wide data", obs1[o0].data, 32'h5A);
            chk("wide rw", obs1[o0].rw, 1'b1);
        end
        check_frame(1'b1, fr, o0, d0, "wide");

        for (int r = 0; r < 50; r++) begin
            int sel, n, mb;
            logic [47:0] dst;
            logic [15:0] et;
            w   = (r >= 38);
            mb  = w ? 6 : 5;
            sel = $urandom_range(0, 9);
            dst = (sel == 0) ? 48'h0000_0000_0001 : (sel < 3) ? BCAST : MAC;
            et  = ($urandom_range(0, 9) == 0) ? 16'h0800 : ETYPE;
            n   = $urandom_range(0, 30);
            build_hdr(dst, et, fr);
            for (int j = 0; j < n; j++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (j % mb == 0) begin
                    case ($urandom_range(0, 5))
                        0: b = 8'h00;
                        1, 2: b = 8'h01;
                        3: b = 8'h07;
                        4: b = 8'hFF;
                        default: ;
                    endcase
                end
                fr.push_back(b);
            end
            o0 = w ? obs1.size() : obs0.size();
            d0 = w ? ndrop1 : ndrop0;
            send_frame(w, fr);
            check_frame(w, fr, o0, d0, $sformatf("rand%0d", r));
        end

        chk("valid and drop never together", both_hi, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ethernet_rx_multi.md
Name: ethernet_rx_multi

Overview:
- Parametrised successor to the single-message RMII Ethernet receive path.
- Consumes raw RMII dibits (50 MHz reference clock, 100 Mb/s, one dibit per cycle).
- Filters frames on destination MAC and ethertype, then parses up to MAX_MSGS back-to-back register-bus messages per frame, with configurable address/data widths.
- Each well-formed read/write message is emitted as a one-cycle request to the downstream bus bridge. Invalid opcodes and truncated messages are dropped and counted.

Parameters:
- FPGA_MAC, 48'h0, destination MAC accepted; broadcast FF:FF:FF:FF:FF:FF is also accepted.
- ETHERTYPE, 16'h0, ethertype accepted; any other value drops the frame.
- ADDR_W, 16, address field width in bits; multiple of 8, range 8..32.
- DATA_W, 16, data field width in bits; multiple of 8, range 8..32.
- MAX_MSGS, 4, maximum messages parsed per frame; further payload bytes are ignored.

Ports:
- clk  in  1  RMII reference clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- crsdv  in  1  RMII carrier-sense/data-valid.
- rxd  in  2  RMII receive dibit.
- addr_o  out  ADDR_W  message address.
- wdata_o  out  DATA_W  message write data; 0 for reads.
- rw_o  out  1  1 = write, 0 = read.
- valid_o  out  1  one-cycle strobe qualifying addr_o, wdata_o and rw_o.
- drop_o  out  1  one-cycle pulse when a frame is rejected or a message is discarded.
- drop_count_o  out  16  saturating count of drop_o pulses.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, all counters 0.
- Byte assembly: dibits arrive LSB-first, 4 per byte. The byte is complete on the cycle its 4th dibit is sampled.
- Multi-byte fields are big-endian (first byte is MSB).
- FSM states:
  - IDLE: on crsdv=1 && rxd=01 -> PREAMBLE.
  - PREAMBLE: rxd=01 stays; rxd=11 (SFD tail) -> DST_MAC and reset the dibit counter; any other value, or crsdv=0 -> IDLE.
  - DST_MAC (6 bytes): at the 6th byte, compare with FPGA_MAC and broadcast. Mismatch -> DROP and pulse drop_o; match -> SRC_MAC.
  - SRC_MAC (6 bytes): contents ignored -> ETHERTYPE.
  - ETHERTYPE (2 bytes): mismatch -> DROP and pulse drop_o; match -> PAYLOAD with msg_idx=0.
  - PAYLOAD: accumulate a message of MB = 1 + ADDR_W/8 + DATA_W/8 bytes. Byte 0 is the opcode, then the address, then the data.
    - On the final byte of a message with opcode 0 or 1: set valid_o=1 on the next cycle (1-cycle latency from the last dibit), drive addr_o and wdata_o, and set rw_o=opcode[0].
    - Other opcodes: pulse drop_o; no valid_o.
    - After either outcome, increment msg_idx. When msg_idx reaches MAX_MSGS -> DROP (silent; not counted).
  - DROP: wait for crsdv=0 -> IDLE.
- Frame end: crsdv=0 in any non-IDLE state returns to IDLE on the next cycle.
  - A partially received message is discarded and counted with a drop_o pulse, but only if at least one byte of that message was received.
  - Ethernet padding/FCS bytes that form trailing partial messages therefore count as drops. Senders zero-pad; opcode-0 padding is still decoded as reads only if a full message fits, so padding should use opcode 8'hFF.
- Read messages: wdata_o = 0.
- addr_o, wdata_o and rw_o hold their values until the next valid_o.
- FCS is not checked in this block.
- drop_count_o saturates at 16'hFFFF.
- valid_o and drop_o are never both high in one cycle, because each message ends in exactly one outcome.
- Reset asserted mid-frame: immediate return to IDLE, no outputs. After reset release the receiver does not resynchronise until a new preamble is seen.

Decomposition:
- Shared package ether_pkg:
  - FSM state enum.
  - Opcode constants OP_READ=8'd0, OP_WRITE=8'd1.
  - BROADCAST_MAC constant.
  - Preamble/SFD dibit constants.
- Sub-module rmii_byte_asm: dibit-to-byte shifter with byte_valid strobe. Its counter is cleared by the parent on SFD and when crsdv=0.

Test Plan:
- FPGA_MAC=48'h12_34_56_78_9A_BC, ETHERTYPE=16'h1234, default widths. Frame with one write {01, 0x0042, 0xBEEF} -> single valid_o with rw_o=1, addr_o=16'h0042, wdata_o=16'hBEEF, 1 cycle after the last dibit.
- Same frame with 3 messages (read 0x0001, write 0x0002/0x00AA, read 0x0003) -> three valid_o pulses 20 cycles apart, with correct fields; read wdata_o=0.
- Destination MAC 00:00:00:00:00:01 -> no valid_o, one drop_o, drop_count_o=1. Broadcast destination -> messages accepted.
- Opcode 8'h07 between two valid writes -> valid, drop, valid. Frame with 6 messages and MAX_MSGS=4 -> exactly 4 valid_o pulses, no extra drops.
- crsdv dropped after 3 bytes of a message -> no valid_o, one drop_o. rst_n pulsed low mid-payload -> outputs 0 immediately; the next clean frame decodes normally.
- ADDR_W=32, DATA_W=8 (MB=6): write {01, 0xDEADBEEF, 0x5A} -> addr_o=32'hDEADBEEF, wdata_o=8'h5A.
